// File: rtl/mem_word_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_access
//  Purpose  : Load/store initiator between the MEM pipeline stage and a
//             byte-wide data memory. One word request is split into BEATS
//             sequential byte accesses. Load bytes are assembled
//             little-endian. A single-cycle response pulse ends each request.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             req_valid/req_ready        - request handshake
//             req_write/req_addr/req_wdata - request fields (store when write)
//             rsp_valid/rsp_err/rsp_rdata  - completion pulse, misalign flag,
//                                            assembled load data
//             MemRead/MemWrite/Address/WriteData/ReadData - memory port
//  Revision : 1.0 - initial release
// ============================================================================
module mem_word_access #(
   parameter int DATA_WIDTH     = 8,
   parameter int DATA_DIR_WIDTH = 8,
   parameter int BEATS          = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [DATA_DIR_WIDTH-1:0]     req_addr,
   input  logic [BEATS*DATA_WIDTH-1:0]   req_wdata,
   output logic                          rsp_valid,
   output logic                          rsp_err,
   output logic [BEATS*DATA_WIDTH-1:0]   rsp_rdata,
   output logic                          MemRead,
   output logic                          MemWrite,
   output logic [DATA_DIR_WIDTH-1:0]     Address,
   output logic [DATA_WIDTH-1:0]         WriteData,
   input  logic [DATA_WIDTH-1:0]         ReadData
);

   localparam int W      = BEATS * DATA_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic                      write_q, write_d;
   logic [DATA_DIR_WIDTH-1:0] addr_q, addr_d;
   logic [W-1:0]              wdata_q, wdata_d;
   logic                      req_ready_q, req_ready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [W-1:0]              rsp_rdata_q, rsp_rdata_d;
   logic                      mem_read_q, mem_read_d;
   logic                      mem_write_q, mem_write_d;
   logic [DATA_DIR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;

   logic                      w_misaligned;

   // A word request is misaligned when any of its low log2(BEATS) address
   // bits is set; with a single beat every address is aligned.
   generate
      if (BEATS > 1) begin : g_align_chk
         assign w_misaligned = |req_addr[BEAT_W-1:0];
      end else begin : g_no_align_chk
         assign w_misaligned = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      req_ready_d  = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      address_d    = address_q;
      write_data_d = write_data_q;

      case (state_q)
         S_IDLE: begin
            // req_ready_q is 0 in the first cycle after reset, so a request
            // is only taken once the ready flag is actually visible outside.
            req_ready_d = 1'b1;
            if (req_ready_q && req_valid) begin
               req_ready_d = 1'b0;
               write_d     = req_write;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               if (w_misaligned) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  // Outputs are registered, so beat 0 is launched here to
                  // appear in the cycle right after the accept edge.
                  state_d      = S_XFER;
                  beat_d       = '0;
                  mem_read_d   = ~req_write;
                  mem_write_d  = req_write;
                  address_d    = req_addr;
                  write_data_d = req_wdata[DATA_WIDTH-1:0];
               end
            end
         end

         S_XFER: begin
            // ReadData belongs to the beat currently on the bus.
            if (!write_q) begin
               rsp_rdata_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = ReadData;
            end
            if (beat_q == LAST_BEAT) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
            end else begin
               beat_d       = beat_q + 1'b1;
               mem_read_d   = ~write_q;
               mem_write_d  = write_q;
               address_d    = addr_q + {{(DATA_DIR_WIDTH-BEAT_W){1'b0}}, beat_d};
               write_data_d = wdata_q[beat_d*DATA_WIDTH +: DATA_WIDTH];
            end
         end

         S_RESP: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         beat_q       <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign MemRead   = mem_read_q;
   assign MemWrite  = mem_write_q;
   assign Address   = address_q;
   assign WriteData = write_data_q;

endmodule
`default_nettype wire
